// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, controller state encoding, control-flow classes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_pkg;

    // Primary opcodes that affect control flow
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;

    // Redirect controller states; the encoding is visible on CtlState
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_LINK = 2'd2
    } ctl_state_e;

    // Control-flow class of the instruction sitting in IF/ID
    typedef enum logic [1:0] {
        SEQ = 2'd0,
        BR  = 2'd1,
        J   = 2'd2,
        JAL = 2'd3
    } cf_class_e;

    // Pseudo-direct jump target in the word-indexed PC space; zero-filled, never sign-extended
    function automatic logic [31:0] jump_target(input logic [31:0] instr);
        return {6'b0, instr[25:0]};
    endfunction

endpackage

// File: rtl/pc_redirect_controller_if.sv
// Bundle between the PC redirect controller and the surrounding pipeline.
// Latency: n/a (wiring only).
// Backpressure: Stall from the hazard unit holds the PC; redirects override it.
interface pc_redirect_controller_if;
    logic [31:0] Instruction;
    logic [31:0] SeqAddress;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        JrValid;
    logic [31:0] JrTarget;
    logic [31:0] NextPC;
    logic        PCWrite;
    logic        FlushIFID;
    logic        WriteRA;
    logic [1:0]  CtlState;

    // Pipeline side: supplies instruction/resolution info, consumes PC controls
    modport master (
        output Instruction, SeqAddress, Stall, BranchTaken, BranchTarget, JrValid, JrTarget,
        input  NextPC, PCWrite, FlushIFID, WriteRA, CtlState
    );

    // Controller side
    modport slave (
        input  Instruction, SeqAddress, Stall, BranchTaken, BranchTarget, JrValid, JrTarget,
        output NextPC, PCWrite, FlushIFID, WriteRA, CtlState
    );
endinterface

// File: rtl/pc_redirect_controller_cf_decode.sv
// Classifies the IF/ID instruction as SEQ, BR, J or JAL from opcode and rt.
// Latency: purely combinational.
// Backpressure: none.
module cf_decode
    import pipeline_pkg::*;
(
    input  logic [31:0] instruction_i,
    output cf_class_e   cls_o
);

    logic [5:0] opcode;
    logic [4:0] rt;
    logic       unused_bits;

    assign opcode      = instruction_i[31:26];
    assign rt          = instruction_i[20:16];
    assign unused_bits = ^{instruction_i[25:21], instruction_i[15:0]};

    // BLEZ/BGTZ are only real branches with rt=0; other rt values fall through as SEQ
    always_comb begin
        cls_o = SEQ;
        case (opcode)
            OP_BEQ, OP_BNE, OP_REGIMM: cls_o = BR;
            OP_BLEZ, OP_BGTZ:          cls_o = (rt == 5'd0) ? BR : SEQ;
            OP_J:                      cls_o = J;
            OP_JAL:                    cls_o = JAL;
            default:                   cls_o = SEQ;
        endcase
    end

endmodule

// File: rtl/pc_redirect_controller.sv
// Sequences the PC: inserts control-flow bubbles and arbitrates EX branch > EX jr > ID jump > sequential.
// Latency: redirects take effect at the next clock edge; J/JAL redirect after the bubble count.
// Backpressure: Stall freezes sequential fetch only; any redirect wins over Stall.
module pc_redirect_controller
    import pipeline_pkg::*;
#(
    parameter int          BRANCH_BUBBLES = 1,
    parameter int          JUMP_BUBBLES   = 1,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  logic                     Clk,
    input  logic                     Reset,
    pc_redirect_controller_if.slave  bus
);

    localparam logic [3:0] BR_CNT = 4'(BRANCH_BUBBLES);
    localparam logic [3:0] J_CNT  = 4'(JUMP_BUBBLES);

    cf_class_e   cls;
    ctl_state_e  state_q, state_d;
    logic [3:0]  bubble_cnt_q, bubble_cnt_d;
    logic        is_jump_q, is_jump_d;
    logic [31:0] jump_tgt_q, jump_tgt_d;
    logic        write_ra_q, write_ra_d;
    logic [31:0] next_pc;
    logic        pc_write;
    logic        flush;

    cf_decode u_decode (
        .instruction_i (bus.Instruction),
        .cls_o         (cls)
    );

    // Redirect arbitration and next-state selection
    always_comb begin
        state_d      = state_q;
        bubble_cnt_d = bubble_cnt_q;
        is_jump_d    = is_jump_q;
        jump_tgt_d   = jump_tgt_q;
        write_ra_d   = 1'b0;
        next_pc      = bus.SeqAddress;
        pc_write     = 1'b0;
        flush        = 1'b0;

        if (bus.BranchTaken) begin
            next_pc      = bus.BranchTarget;
            pc_write     = 1'b1;
            flush        = 1'b1;
            state_d      = ST_RUN;
            bubble_cnt_d = 4'd0;
            is_jump_d    = 1'b0;
        end else if (bus.JrValid) begin
            next_pc      = bus.JrTarget;
            pc_write     = 1'b1;
            flush        = 1'b1;
            state_d      = ST_RUN;
            bubble_cnt_d = 4'd0;
            is_jump_d    = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    case (cls)
                        JAL: begin
                            state_d    = ST_LINK;
                            jump_tgt_d = jump_target(bus.Instruction);
                            write_ra_d = 1'b1;
                        end
                        J: begin
                            state_d      = ST_HOLD;
                            bubble_cnt_d = J_CNT;
                            is_jump_d    = 1'b1;
                            jump_tgt_d   = jump_target(bus.Instruction);
                        end
                        BR: begin
                            state_d      = ST_HOLD;
                            bubble_cnt_d = BR_CNT;
                            is_jump_d    = 1'b0;
                        end
                        default: pc_write = !bus.Stall;
                    endcase
                end
                ST_HOLD: begin
                    // The count keeps running under Stall; a branch just releases back to RUN
                    if (bubble_cnt_q > 4'd1) begin
                        bubble_cnt_d = bubble_cnt_q - 4'd1;
                    end else begin
                        state_d      = ST_RUN;
                        bubble_cnt_d = 4'd0;
                        is_jump_d    = 1'b0;
                        if (is_jump_q) begin
                            next_pc  = jump_tgt_q;
                            pc_write = 1'b1;
                            flush    = 1'b1;
                        end
                    end
                end
                ST_LINK: begin
                    state_d      = ST_HOLD;
                    bubble_cnt_d = J_CNT;
                    is_jump_d    = 1'b1;
                end
                default: begin
                    state_d      = ST_RUN;
                    bubble_cnt_d = 4'd0;
                    is_jump_d    = 1'b0;
                end
            endcase
        end
    end

    // Controller state; WriteRA is registered so it is high exactly while in LINK
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_RUN;
            bubble_cnt_q <= 4'd0;
            is_jump_q    <= 1'b0;
            jump_tgt_q   <= 32'd0;
            write_ra_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bubble_cnt_q <= bubble_cnt_d;
            is_jump_q    <= is_jump_d;
            jump_tgt_q   <= jump_tgt_d;
            write_ra_q   <= write_ra_d;
        end
    end

    // Reset forces a load of RESET_PC into the PC register and clears IF/ID
    assign bus.NextPC    = Reset ? RESET_PC : next_pc;
    assign bus.PCWrite   = Reset | pc_write;
    assign bus.FlushIFID = Reset | flush;
    assign bus.WriteRA   = write_ra_q;
    assign bus.CtlState  = state_q;

    // Zero bubbles would make HOLD meaningless and 4 bits cap the count
    param_range_a: assert property (@(posedge Clk)
        (BRANCH_BUBBLES >= 1) && (BRANCH_BUBBLES <= 15) &&
        (JUMP_BUBBLES >= 1) && (JUMP_BUBBLES <= 15));

endmodule

// File: tb/tb_pc_redirect_controller.sv
module tb_pc_redirect_controller;
    import pipeline_pkg::*;

    logic        Clk;
    logic        Reset;
    logic [31:0] pc;
    logic [31:0] ref_instr;
    cf_class_e   ref_cls;
    int          total;
    int          bad;

    pc_redirect_controller_if bus ();

    pc_redirect_controller #(
        .BRANCH_BUBBLES (1),
        .JUMP_BUBBLES   (1),
        .RESET_PC       (32'h0)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    cf_decode u_ref (
        .instruction_i (ref_instr),
        .cls_o         (ref_cls)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Plain enabled PC register fed by the controller
    always @(posedge Clk) begin
        if (bus.PCWrite) pc <= bus.NextPC;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] rest);
        return {op, rest};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        pc    = 32'hDEAD_BEEF;
        Reset = 1'b1;
        ref_instr        = 32'd0;
        bus.Instruction  = 32'd0;
        bus.SeqAddress   = 32'd0;
        bus.Stall        = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchTarget = 32'd0;
        bus.JrValid      = 1'b0;
        bus.JrTarget     = 32'd0;
        #1;
        chk("rst_npc",   bus.NextPC, 32'h0);
        chk("rst_pcw",   {31'd0, bus.PCWrite}, 32'd1);
        chk("rst_flush", {31'd0, bus.FlushIFID}, 32'd1);
        chk("rst_wra",   {31'd0, bus.WriteRA}, 32'd0);
        chk("rst_state", {30'd0, bus.CtlState}, 32'd0);

        // Release reset with a SEQ instruction
        tick(); tick();
        Reset = 1'b0;
        bus.SeqAddress = 32'h1;
        #1;
        chk("seq_npc", bus.NextPC, 32'h1);
        chk("seq_pcw", {31'd0, bus.PCWrite}, 32'd1);
        tick();
        chk("seq_pc", pc, 32'h1);

        // BEQ not taken: two cycles without PC write, no flush, then sequential
        bus.SeqAddress  = 32'h11;
        bus.Instruction = mk(OP_BEQ, 26'h0);
        #1;
        chk("br_dec_pcw",   {31'd0, bus.PCWrite}, 32'd0);
        chk("br_dec_flush", {31'd0, bus.FlushIFID}, 32'd0);
        tick();
        bus.Instruction = 32'd0;
        #1;
        chk("br_hold_state", {30'd0, bus.CtlState}, 32'd1);
        chk("br_hold_pcw",   {31'd0, bus.PCWrite}, 32'd0);
        chk("br_hold_flush", {31'd0, bus.FlushIFID}, 32'd0);
        tick();
        chk("br_run_state", {30'd0, bus.CtlState}, 32'd0);
        chk("br_run_npc",   bus.NextPC, 32'h11);
        chk("br_run_pcw",   {31'd0, bus.PCWrite}, 32'd1);
        tick();

        // J to 0x40
        bus.Instruction = mk(OP_J, 26'h40);
        #1;
        chk("j_dec_pcw", {31'd0, bus.PCWrite}, 32'd0);
        tick();
        bus.Instruction = 32'd0;
        #1;
        chk("j_hold_state", {30'd0, bus.CtlState}, 32'd1);
        chk("j_npc",        bus.NextPC, 32'h40);
        chk("j_pcw",        {31'd0, bus.PCWrite}, 32'd1);
        chk("j_flush",      {31'd0, bus.FlushIFID}, 32'd1);
        tick();
        chk("j_pc",        pc, 32'h40);
        chk("j_run_state", {30'd0, bus.CtlState}, 32'd0);

        // JAL to 0x80: LINK (WriteRA) then one HOLD cycle then redirect
        bus.Instruction = mk(OP_JAL, 26'h80);
        #1;
        chk("jal_dec_pcw", {31'd0, bus.PCWrite}, 32'd0);
        chk("jal_dec_wra", {31'd0, bus.WriteRA}, 32'd0);
        tick();
        chk("jal_link_state", {30'd0, bus.CtlState}, 32'd2);
        chk("jal_link_wra",   {31'd0, bus.WriteRA}, 32'd1);
        chk("jal_link_pcw",   {31'd0, bus.PCWrite}, 32'd0);
        tick();
        bus.Instruction = 32'd0;
        #1;
        chk("jal_hold_state", {30'd0, bus.CtlState}, 32'd1);
        chk("jal_hold_wra",   {31'd0, bus.WriteRA}, 32'd0);
        chk("jal_npc",        bus.NextPC, 32'h80);
        chk("jal_flush",      {31'd0, bus.FlushIFID}, 32'd1);
        tick();
        chk("jal_pc",      pc, 32'h80);
        chk("jal_run_wra", {31'd0, bus.WriteRA}, 32'd0);

        // Branch taken during HOLD of a J drops the pending jump
        bus.Instruction = mk(OP_J, 26'h40);
        tick();
        bus.Instruction  = 32'd0;
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 32'h25;
        #1;
        chk("bt_npc",   bus.NextPC, 32'h25);
        chk("bt_pcw",   {31'd0, bus.PCWrite}, 32'd1);
        chk("bt_flush", {31'd0, bus.FlushIFID}, 32'd1);
        tick();
        bus.BranchTaken = 1'b0;
        #1;
        chk("bt_pc",    pc, 32'h25);
        chk("bt_state", {30'd0, bus.CtlState}, 32'd0);
        chk("bt_npc2",  bus.NextPC, 32'h11);
        tick();

        // Stall three cycles, then jr arrives as Stall drops
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_pcw", {31'd0, bus.PCWrite}, 32'd0);
            tick();
        end
        bus.Stall    = 1'b0;
        bus.JrValid  = 1'b1;
        bus.JrTarget = 32'h33;
        #1;
        chk("jr_npc",   bus.NextPC, 32'h33);
        chk("jr_flush", {31'd0, bus.FlushIFID}, 32'd1);
        tick();
        chk("jr_pc", pc, 32'h33);

        // Branch beats jr, and both beat Stall
        bus.Stall        = 1'b1;
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 32'h25;
        #1;
        chk("prio_npc", bus.NextPC, 32'h25);
        chk("prio_pcw", {31'd0, bus.PCWrite}, 32'd1);
        tick();
        bus.Stall       = 1'b0;
        bus.BranchTaken = 1'b0;
        bus.JrValid     = 1'b0;

        // BLEZ with rt=0 is a branch; BGTZ with rt!=0 is sequential
        bus.Instruction = mk(OP_BLEZ, 26'h0);
        #1;
        chk("blez_pcw", {31'd0, bus.PCWrite}, 32'd0);
        tick();
        bus.Instruction = 32'd0;
        #1;
        chk("blez_state", {30'd0, bus.CtlState}, 32'd1);
        tick();
        bus.Instruction = mk(OP_BGTZ, {5'd0, 5'd3, 16'h0});
        #1;
        chk("bgtz_rt_pcw",   {31'd0, bus.PCWrite}, 32'd1);
        chk("bgtz_rt_state", {30'd0, bus.CtlState}, 32'd0);
        tick();

        // Jump target is zero-filled, not sign-extended
        bus.Instruction = mk(OP_J, 26'h3FF_FFFF);
        tick();
        bus.Instruction = 32'd0;
        #1;
        chk("j_noext_npc", bus.NextPC, 32'h03FF_FFFF);
        tick();

        // Reference decoder spot checks
        ref_instr = mk(OP_REGIMM, 26'h0);
        #1 chk("dec_regimm", {30'd0, ref_cls}, 32'd1);
        ref_instr = mk(OP_BNE, 26'h12345);
        #1 chk("dec_bne", {30'd0, ref_cls}, 32'd1);
        ref_instr = mk(OP_BGTZ, {5'd0, 5'd3, 16'h0});
        #1 chk("dec_bgtz_rt", {30'd0, ref_cls}, 32'd0);
        ref_instr = mk(OP_J, 26'h40);
        #1 chk("dec_j", {30'd0, ref_cls}, 32'd2);
        ref_instr = mk(OP_JAL, 26'h80);
        #1 chk("dec_jal", {30'd0, ref_cls}, 32'd3);
        ref_instr = mk(6'b100011, 26'h0);
        #1 chk("dec_lw", {30'd0, ref_cls}, 32'd0);

        // Reset in the middle of LINK aborts with no clock edge
        tick();
        bus.Instruction = mk(OP_JAL, 26'h80);
        tick();
        chk("rl_link_state", {30'd0, bus.CtlState}, 32'd2);
        chk("rl_link_wra",   {31'd0, bus.WriteRA}, 32'd1);
        Reset = 1'b1;
        bus.Instruction = 32'd0;
        #1;
        chk("rl_npc",   bus.NextPC, 32'h0);
        chk("rl_pcw",   {31'd0, bus.PCWrite}, 32'd1);
        chk("rl_flush", {31'd0, bus.FlushIFID}, 32'd1);
        chk("rl_wra",   {31'd0, bus.WriteRA}, 32'd0);
        chk("rl_state", {30'd0, bus.CtlState}, 32'd0);
        tick();
        Reset = 1'b0;
        bus.SeqAddress = 32'h1;
        #1;
        chk("rl_rel_npc", bus.NextPC, 32'h1);
        chk("rl_rel_wra", {31'd0, bus.WriteRA}, 32'd0);
        tick();
        chk("rl_rel_pc", pc, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
